// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: display scan-out reads win their slot, host uses the rest.
// Optional build macro FB_ARB_BLANK_ONLY_EN restricts host grants to vertical blanking.
module fb_port_arbiter #(
    parameter int X_RES   = 640,
    parameter int Y_RES   = 480,
    parameter int PIX_W   = 8,
    parameter int PPW     = 4,
    parameter int ADDR_W  = 17,
    parameter int RAM_LAT = 1
) (
    input  logic                   clk_pix,
    input  logic                   rst,
    input  logic [9:0]             sx,
    input  logic [9:0]             sy,
    input  logic                   de,
    input  logic                   hsync,
    input  logic                   vsync,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [PIX_W*PPW-1:0]   mem_wdata,
    input  logic [PIX_W*PPW-1:0]   mem_rdata,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [PIX_W*PPW-1:0]   host_wdata,
    output logic                   host_gnt,
    output logic [PIX_W*PPW-1:0]   host_rdata,
    output logic                   host_rvalid,
    output logic [PIX_W-1:0]       pix_o,
    output logic                   de_o,
    output logic                   hsync_o,
    output logic                   vsync_o
);
    localparam int WORD_W     = PIX_W * PPW;
    localparam int PPW_LOG2   = $clog2(PPW);
    localparam int CNT_W      = $clog2(PPW) + 1;
    localparam int OUT_LAT    = RAM_LAT + 1;
    localparam int LINE_WORDS = X_RES / PPW;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_HBLANK = 2'd1,
        PH_VBLANK = 2'd2
    } phase_t;

    phase_t               phase_r;
    phase_t               phase_next_s;
    logic                 disp_slot_s;
    logic                 host_ok_s;
    logic [ADDR_W-1:0]    line_base_r;
    logic [ADDR_W-1:0]    base_eff_s;
    logic [RAM_LAT-1:0]   disp_pipe_r;
    logic [RAM_LAT-1:0]   host_pipe_r;
    logic [WORD_W-1:0]    shreg_r;
    logic [CNT_W-1:0]     rem_r;
    logic [PIX_W-1:0]     pix_r;
    logic [WORD_W-1:0]    host_rdata_r;
    logic [OUT_LAT-1:0]   de_d_r;
    logic [OUT_LAT-1:0]   hs_d_r;
    logic [OUT_LAT-1:0]   vs_d_r;

    // Phase classification of the current timing-generator position.
    always_comb begin
        phase_next_s = PH_HBLANK;
        if (sy >= 10'(Y_RES)) begin
            phase_next_s = PH_VBLANK;
        end else if (de) begin
            phase_next_s = PH_ACTIVE;
        end else begin
            phase_next_s = PH_HBLANK;
        end
    end

    // Slot decision and RAM port mux; the frame-start base is forced to zero so word 0 is read on time.
    always_comb begin
        disp_slot_s = de && ((sx & 10'(PPW - 1)) == 10'd0);
`ifdef FB_ARB_BLANK_ONLY_EN
        host_ok_s   = (phase_next_s == PH_VBLANK);
`else
        host_ok_s   = 1'b1;
`endif
        if ((sx == 10'd0) && (sy == 10'd0)) begin
            base_eff_s = '0;
        end else begin
            base_eff_s = line_base_r;
        end
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        host_gnt  = 1'b0;
        if (disp_slot_s) begin
            mem_en   = 1'b1;
            mem_addr = base_eff_s + ADDR_W'(sx >> PPW_LOG2);
        end else if (host_req && host_ok_s) begin
            mem_en   = 1'b1;
            mem_we   = host_we;
            host_gnt = 1'b1;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Phase register and per-line word base.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            phase_r     <= PH_VBLANK;
            line_base_r <= '0;
        end else begin
            phase_r <= phase_next_s;
            if ((sx == 10'd0) && (sy == 10'd0)) begin
                line_base_r <= '0;
            end else if (de && (sx == 10'(X_RES - 1))) begin
                line_base_r <= line_base_r + ADDR_W'(LINE_WORDS);
            end else begin
                line_base_r <= line_base_r;
            end
        end
    end

    // Read-in-flight flag pipelines matching the RAM latency.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            disp_pipe_r <= '0;
            host_pipe_r <= '0;
        end else begin
            disp_pipe_r[0] <= disp_slot_s;
            host_pipe_r[0] <= host_gnt && !host_we;
            for (int i = 1; i < RAM_LAT; i++) begin
                disp_pipe_r[i] <= disp_pipe_r[i-1];
                host_pipe_r[i] <= host_pipe_r[i-1];
            end
        end
    end

    // Word unpacker: pixel 0 straight from the RAM, the rest shifted out one per cycle.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            shreg_r <= '0;
            rem_r   <= '0;
            pix_r   <= '0;
        end else if (disp_pipe_r[RAM_LAT-1]) begin
            shreg_r <= mem_rdata >> PIX_W;
            pix_r   <= mem_rdata[PIX_W-1:0];
            rem_r   <= CNT_W'(PPW - 1);
        end else if (rem_r != '0) begin
            shreg_r <= shreg_r >> PIX_W;
            pix_r   <= shreg_r[PIX_W-1:0];
            rem_r   <= rem_r - CNT_W'(1);
        end else begin
            pix_r   <= '0;
        end
    end

    // Host read data holding register.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            host_rdata_r <= '0;
        end else if (host_pipe_r[RAM_LAT-1]) begin
            host_rdata_r <= mem_rdata;
        end else begin
            host_rdata_r <= host_rdata_r;
        end
    end

    // Sync and data-enable delay line, same depth as the pixel path.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            de_d_r <= '0;
            hs_d_r <= '1;
            vs_d_r <= '1;
        end else begin
            de_d_r[0] <= de;
            hs_d_r[0] <= hsync;
            vs_d_r[0] <= vsync;
            for (int i = 1; i < OUT_LAT; i++) begin
                de_d_r[i] <= de_d_r[i-1];
                hs_d_r[i] <= hs_d_r[i-1];
                vs_d_r[i] <= vs_d_r[i-1];
            end
        end
    end

    // Host read return; a read still in flight while reset is high is suppressed.
    always_comb begin
        host_rvalid = host_pipe_r[RAM_LAT-1] && !rst;
        if (host_rvalid) begin
            host_rdata = mem_rdata;
        end else begin
            host_rdata = host_rdata_r;
        end
    end

    assign pix_o   = pix_r;
    assign de_o    = de_d_r[OUT_LAT-1];
    assign hsync_o = hs_d_r[OUT_LAT-1];
    assign vsync_o = vs_d_r[OUT_LAT-1];

    fb_port_arbiter_chk #(
        .X_RES (X_RES),
        .PPW   (PPW)
    ) u_chk (
        .clk_pix    (clk_pix),
        .rst        (rst),
        .disp_slot  (disp_slot_s),
        .host_gnt   (host_gnt),
        .phase_q    (phase_r),
        .phase_next (phase_next_s)
    );
endmodule

// Simulation checks for the arbiter: configuration legality and slot exclusivity.
module fb_port_arbiter_chk #(
    parameter int X_RES = 640,
    parameter int PPW   = 4
) (
    input logic       clk_pix,
    input logic       rst,
    input logic       disp_slot,
    input logic       host_gnt,
    input logic [1:0] phase_q,
    input logic [1:0] phase_next
);
    a_ppw_divides: assert property (@(posedge clk_pix) (X_RES % PPW) == 0);
    a_no_gnt_in_slot: assert property (@(posedge clk_pix) disable iff (rst) !(disp_slot && host_gnt));
    a_phase_tracks: assert property (@(posedge clk_pix) disable iff (rst) 1'b1 |=> (phase_q == $past(phase_next)));
endmodule
